// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 FFT address generator.
package fft_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Rotate the low 'width' bits of value left by 'amount' (0 <= amount < width).
  function automatic logic [31:0] rotl(input logic [31:0] value, input int amount, input int width);
    logic [31:0] mask;
    logic [31:0] v;
    mask = (32'd1 << width) - 32'd1;
    v    = value & mask;
    return ((v << amount) | (v >> (width - amount))) & mask;
  endfunction

  // Mask with the top s bits of a width-bit field set.
  function automatic logic [31:0] tw_mask(input int s, input int width);
    logic [31:0] full;
    full = (32'd1 << width) - 32'd1;
    return full & ~((32'd1 << (width - s)) - 32'd1);
  endfunction

endpackage

// File: rtl/fft_agu_pipe_if.sv
// Control handshake plus RAM/twiddle address bus of the FFT address generator.
interface fft_agu_pipe_if #(
  parameter int LOG_N = 9,
  parameter int STG_W = $clog2(LOG_N + 1)
);
  logic             start;
  logic             abort;
  logic             inverse;
  logic             busy;
  logic             done;
  logic [STG_W-1:0] stage;
  logic             rd_en;
  logic [LOG_N-1:0] rd_addr_a;
  logic [LOG_N-1:0] rd_addr_b;
  logic [LOG_N-2:0] tw_addr;
  logic             tw_conj;
  logic             wr_en;
  logic [LOG_N-1:0] wr_addr_a;
  logic [LOG_N-1:0] wr_addr_b;

  // master: the address generator, which drives the RAM side
  modport master (
    input  start, abort, inverse,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr, tw_conj,
           wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start, abort, inverse,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr, tw_conj,
           wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_pipe_delay.sv
// Fixed-depth shift register carrying a valid bit and payload; flush drops all valids.
module fft_pipe_delay #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic         vld_reg;
      logic [W-1:0] data_reg;
      logic         vld_in;
      logic [W-1:0] data_in;

      if (gi == 0) begin : g_head
        assign vld_in  = in_valid;
        assign data_in = in_data;
      end else begin : g_link
        assign vld_in  = g_stage[gi-1].vld_reg;
        assign data_in = g_stage[gi-1].data_reg;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_reg  <= 1'b0;
          data_reg <= '0;
        end else begin
          vld_reg  <= vld_in & ~flush;
          data_reg <= data_in;
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[DEPTH-1].vld_reg;
  assign out_data  = g_stage[DEPTH-1].data_reg;

endmodule

// File: rtl/fft_agu_pipe.sv
// In-place radix-2 FFT sequencer: one butterfly read per clock, writes replayed LAT cycles
// later, with a LAT-cycle drain between stages so no stage reads data still in flight.
module fft_agu_pipe
  import fft_pkg::*;
#(
  parameter int LOG_N = 9,
  parameter int LAT   = 3,
  parameter int STG_W = $clog2(LOG_N + 1)
) (
  input logic            clk,
  input logic            reset,
  fft_agu_pipe_if.master bus
);

  localparam int TW_W = LOG_N - 1;
  localparam int D_W  = (LAT > 1) ? $clog2(LAT) : 1;

  state_t           state_reg;
  logic [STG_W-1:0] s_reg;
  logic [TW_W-1:0]  j_reg;
  logic [D_W-1:0]   d_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             rd_en_reg;
  logic             conj_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      j_reg     <= '0;
      d_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      rd_en_reg <= 1'b0;
      conj_reg  <= 1'b0;
    end else if (bus.abort) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      rd_en_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg <= RUN;
            conj_reg  <= bus.inverse;
            s_reg     <= '0;
            j_reg     <= '0;
            busy_reg  <= 1'b1;
            rd_en_reg <= 1'b1;
          end
        end
        RUN: begin
          if (j_reg == '1) begin
            state_reg <= DRAIN;
            d_reg     <= '0;
            rd_en_reg <= 1'b0;
          end else begin
            j_reg <= j_reg + TW_W'(1);
          end
        end
        DRAIN: begin
          if (d_reg == D_W'(LAT - 1)) begin
            if (s_reg == STG_W'(LOG_N - 1)) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
              s_reg     <= s_reg + STG_W'(1);
              j_reg     <= '0;
              rd_en_reg <= 1'b1;
            end
          end else begin
            d_reg <= d_reg + D_W'(1);
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [LOG_N-1:0] ja;
  logic [LOG_N-1:0] jb;
  logic [LOG_N-1:0] rd_addr_a;
  logic [LOG_N-1:0] rd_addr_b;
  logic [TW_W-1:0]  tw_addr;

  assign ja = {j_reg, 1'b0};
  assign jb = {j_reg, 1'b1};

  // Addresses are forced to zero while not reading so idle outputs stay quiet.
  assign rd_addr_a = rd_en_reg ? LOG_N'(rotl(32'(ja), int'(s_reg), LOG_N)) : '0;
  assign rd_addr_b = rd_en_reg ? LOG_N'(rotl(32'(jb), int'(s_reg), LOG_N)) : '0;
  assign tw_addr   = rd_en_reg ? (j_reg & TW_W'(tw_mask(int'(s_reg), TW_W))) : '0;

  logic [2*LOG_N-1:0] dly_data;
  logic               dly_valid;

  fft_pipe_delay #(
    .W     (2 * LOG_N),
    .DEPTH (LAT)
  ) u_wr_delay (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.abort),
    .in_valid  (rd_en_reg),
    .in_data   ({rd_addr_a, rd_addr_b}),
    .out_valid (dly_valid),
    .out_data  (dly_data)
  );

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.stage     = s_reg;
  assign bus.rd_en     = rd_en_reg;
  assign bus.rd_addr_a = rd_addr_a;
  assign bus.rd_addr_b = rd_addr_b;
  assign bus.tw_addr   = tw_addr;
  assign bus.tw_conj   = conj_reg;
  assign bus.wr_en     = dly_valid;
  assign bus.wr_addr_a = dly_data[2*LOG_N-1:LOG_N];
  assign bus.wr_addr_b = dly_data[LOG_N-1:0];

endmodule

// File: tb/tb_fft_agu_pipe.sv
// Bench for fft_agu_pipe: a small (N=8, LAT=2) and a full-size (N=512, LAT=3) instance,
// read/write address streams checked against scoreboard queues.
module tb_fft_agu_pipe;

  localparam int SN = 3;
  localparam int SL = 2;
  localparam int LN = 9;
  localparam int LL = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fft_agu_pipe_if #(.LOG_N(SN)) bus_s ();
  fft_agu_pipe_if #(.LOG_N(LN)) bus_l ();

  fft_agu_pipe #(.LOG_N(SN), .LAT(SL)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));
  fft_agu_pipe #(.LOG_N(LN), .LAT(LL)) dut_l (.clk(clk), .reset(reset), .bus(bus_l));

  int vectors = 0;
  int miscompares = 0;

  // Small-instance expected read order over the three stages.
  int tab_a [12] = '{0, 2, 4, 6, 0, 4, 1, 5, 0, 1, 2, 3};
  int tab_b [12] = '{1, 3, 5, 7, 2, 6, 3, 7, 4, 5, 6, 7};
  int tab_t [12] = '{0, 0, 0, 0, 0, 0, 2, 2, 0, 1, 2, 3};

  logic [8:0]  sq_rd[$];
  logic [5:0]  sq_wr[$];
  logic [26:0] lq_rd[$];
  logic [17:0] lq_wr[$];
  logic [8:0]  s_rd_exp;
  logic [5:0]  s_wr_exp;
  logic [26:0] l_rd_exp;
  logic [17:0] l_wr_exp;

  // Scoreboard monitors: every strobe pops one expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_s.rd_en === 1'b1) begin
        vectors++;
        if (sq_rd.size() == 0) begin
          miscompares++;
          $display("FAIL s_rd unexpected read got=%h exp=none", {bus_s.rd_addr_a, bus_s.rd_addr_b});
        end else begin
          s_rd_exp = sq_rd.pop_front();
          if ({bus_s.rd_addr_a, bus_s.rd_addr_b, bus_s.tw_addr, bus_s.tw_conj} !== s_rd_exp) begin
            miscompares++;
            $display("FAIL s_rd got=%h exp=%h",
                     {bus_s.rd_addr_a, bus_s.rd_addr_b, bus_s.tw_addr, bus_s.tw_conj}, s_rd_exp);
          end
        end
      end
      if (bus_s.wr_en === 1'b1) begin
        vectors++;
        if (sq_wr.size() == 0) begin
          miscompares++;
          $display("FAIL s_wr unexpected write got=%h exp=none", {bus_s.wr_addr_a, bus_s.wr_addr_b});
        end else begin
          s_wr_exp = sq_wr.pop_front();
          if ({bus_s.wr_addr_a, bus_s.wr_addr_b} !== s_wr_exp) begin
            miscompares++;
            $display("FAIL s_wr got=%h exp=%h", {bus_s.wr_addr_a, bus_s.wr_addr_b}, s_wr_exp);
          end
        end
      end
      if (bus_l.rd_en === 1'b1) begin
        vectors++;
        if (lq_rd.size() == 0) begin
          miscompares++;
          $display("FAIL l_rd unexpected read got=%h exp=none", {bus_l.rd_addr_a, bus_l.rd_addr_b});
        end else begin
          l_rd_exp = lq_rd.pop_front();
          if ({bus_l.rd_addr_a, bus_l.rd_addr_b, bus_l.tw_addr, bus_l.tw_conj} !== l_rd_exp) begin
            miscompares++;
            $display("FAIL l_rd got=%h exp=%h",
                     {bus_l.rd_addr_a, bus_l.rd_addr_b, bus_l.tw_addr, bus_l.tw_conj}, l_rd_exp);
          end
        end
      end
      if (bus_l.wr_en === 1'b1) begin
        vectors++;
        if (lq_wr.size() == 0) begin
          miscompares++;
          $display("FAIL l_wr unexpected write got=%h exp=none", {bus_l.wr_addr_a, bus_l.wr_addr_b});
        end else begin
          l_wr_exp = lq_wr.pop_front();
          if ({bus_l.wr_addr_a, bus_l.wr_addr_b} !== l_wr_exp) begin
            miscompares++;
            $display("FAIL l_wr got=%h exp=%h", {bus_l.wr_addr_a, bus_l.wr_addr_b}, l_wr_exp);
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_small(input logic conj, input int first, input int count, input bit with_wr);
    for (int i = first; i < first + count; i++) begin
      logic [2:0] a;
      logic [2:0] b;
      logic [1:0] t;
      a = 3'(tab_a[i]);
      b = 3'(tab_b[i]);
      t = 2'(tab_t[i]);
      sq_rd.push_back({a, b, t, conj});
      if (with_wr) sq_wr.push_back({a, b});
    end
  endtask

  function automatic int rotl_ref(input int v, input int s, input int w);
    int r;
    r = 0;
    for (int i = 0; i < w; i++)
      if (((v >> i) & 1) != 0) r = r | (1 << ((i + s) % w));
    return r;
  endfunction

  task automatic push_large(input logic conj);
    for (int s = 0; s < LN; s++) begin
      for (int j = 0; j < (1 << (LN - 1)); j++) begin
        logic [8:0] a;
        logic [8:0] b;
        logic [7:0] t;
        a = 9'(rotl_ref(2 * j, s, LN));
        b = 9'(rotl_ref(2 * j + 1, s, LN));
        t = 8'(j & (((1 << s) - 1) << (LN - 1 - s)));
        lq_rd.push_back({a, b, t, conj});
        lq_wr.push_back({a, b});
      end
    end
  endtask

  // {busy, done, rd_en, wr_en, tw_conj, stage} of the small instance at cycle c after start.
  function automatic logic [6:0] exp_ctl(input int c, input logic conj);
    logic       b;
    logic       d;
    logic       r;
    logic       w;
    logic [1:0] st;
    b  = (c >= 1 && c <= 18);
    d  = (c == 19);
    r  = b && (((c - 1) % 6) < 4);
    w  = (c >= 3 && c <= 18 && (((c - 3) % 6) < 4));
    st = (c >= 19) ? 2'd2 : 2'((c - 1) / 6);
    return {b, d, r, w, conj, st};
  endfunction

  function automatic logic [6:0] got_ctl();
    return {bus_s.busy, bus_s.done, bus_s.rd_en, bus_s.wr_en, bus_s.tw_conj, bus_s.stage};
  endfunction

  task automatic check_drained(input string name);
    vectors++;
    if (sq_rd.size() != 0 || sq_wr.size() != 0 || lq_rd.size() != 0 || lq_wr.size() != 0) begin
      miscompares++;
      $display("FAIL %s leftover got=%0d/%0d/%0d/%0d exp=0/0/0/0", name,
               sq_rd.size(), sq_wr.size(), lq_rd.size(), lq_wr.size());
    end
  endtask

  task automatic test_reset();
    bus_s.start = 1'b0; bus_s.abort = 1'b0; bus_s.inverse = 1'b0;
    bus_l.start = 1'b0; bus_l.abort = 1'b0; bus_l.inverse = 1'b0;
    reset = 1'b1;
    next_cycle();
    vectors++;
    if ({got_ctl(), bus_s.rd_addr_a, bus_s.rd_addr_b, bus_s.tw_addr, bus_s.wr_addr_a, bus_s.wr_addr_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_small got=%h exp=0",
               {got_ctl(), bus_s.rd_addr_a, bus_s.rd_addr_b, bus_s.tw_addr, bus_s.wr_addr_a, bus_s.wr_addr_b});
    end
    vectors++;
    if ({bus_l.busy, bus_l.done, bus_l.rd_en, bus_l.wr_en, bus_l.tw_conj, bus_l.stage,
         bus_l.rd_addr_a, bus_l.rd_addr_b, bus_l.tw_addr, bus_l.wr_addr_a, bus_l.wr_addr_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_large got=%b exp=0", {bus_l.busy, bus_l.rd_en, bus_l.wr_en, bus_l.stage});
    end
    reset = 1'b0;
    next_cycle();
    vectors++;
    if ({bus_s.busy, bus_l.busy, bus_s.rd_en, bus_l.rd_en} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_idle got=%b exp=0000", {bus_s.busy, bus_l.busy, bus_s.rd_en, bus_l.rd_en});
    end
  endtask

  // Full small run; optionally a second start (with the opposite inverse) mid-run.
  task automatic test_full_run(input logic inv, input bit mid_start);
    logic [6:0] e;
    push_small(inv, 0, 12, 1'b1);
    bus_s.start = 1'b1;
    bus_s.inverse = inv;
    for (int c = 1; c <= 19; c++) begin
      next_cycle();
      bus_s.start = (mid_start && c == 5);
      bus_s.inverse = (mid_start && c == 5) ? ~inv : inv;
      e = exp_ctl(c, inv);
      vectors++;
      if (got_ctl() !== e) begin
        miscompares++;
        $display("FAIL run_ctl cyc=%0d got=%b exp=%b", c, got_ctl(), e);
      end
    end
    next_cycle();
    check_drained("run_queues");
  endtask

  task automatic test_start_held();
    logic [6:0] e;
    push_small(1'b0, 0, 12, 1'b1);
    push_small(1'b0, 0, 1, 1'b0);
    bus_s.start = 1'b1;
    bus_s.inverse = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      next_cycle();
      vectors++;
      if (c <= 19) begin
        e = exp_ctl(c, 1'b0);
        if (got_ctl() !== e) begin
          miscompares++;
          $display("FAIL held_ctl cyc=%0d got=%b exp=%b", c, got_ctl(), e);
        end
      end else if (c == 20) begin
        if ({bus_s.busy, bus_s.done, bus_s.rd_en, bus_s.wr_en} !== 4'b0000) begin
          miscompares++;
          $display("FAIL held_idle got=%b exp=0000", {bus_s.busy, bus_s.done, bus_s.rd_en, bus_s.wr_en});
        end
      end else begin
        if ({bus_s.busy, bus_s.rd_en, bus_s.stage} !== 4'b1100) begin
          miscompares++;
          $display("FAIL held_restart got=%b exp=1100", {bus_s.busy, bus_s.rd_en, bus_s.stage});
        end
        bus_s.start = 1'b0;
        bus_s.abort = 1'b1;
      end
    end
    for (int c = 22; c <= 25; c++) begin
      next_cycle();
      bus_s.abort = 1'b0;
      vectors++;
      if ({bus_s.busy, bus_s.done, bus_s.wr_en} !== 3'b000) begin
        miscompares++;
        $display("FAIL held_abort cyc=%0d got=%b exp=000", c, {bus_s.busy, bus_s.done, bus_s.wr_en});
      end
    end
    check_drained("held_queues");
  endtask

  task automatic test_abort();
    logic [6:0] e;
    push_small(1'b1, 0, 4, 1'b1);
    push_small(1'b1, 4, 2, 1'b0);
    bus_s.start = 1'b1;
    bus_s.inverse = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      next_cycle();
      bus_s.start = 1'b0;
      bus_s.abort = (c == 8);
      vectors++;
      if (c <= 8) begin
        e = exp_ctl(c, 1'b1);
        if (got_ctl() !== e) begin
          miscompares++;
          $display("FAIL abort_ctl cyc=%0d got=%b exp=%b", c, got_ctl(), e);
        end
      end else if ({bus_s.busy, bus_s.done, bus_s.rd_en, bus_s.wr_en, bus_s.tw_conj} !== 5'b00001) begin
        miscompares++;
        $display("FAIL abort_after cyc=%0d got=%b exp=00001", c,
                 {bus_s.busy, bus_s.done, bus_s.rd_en, bus_s.wr_en, bus_s.tw_conj});
      end
    end
    check_drained("abort_queues");
  endtask

  task automatic test_abort_start_idle();
    bus_s.start = 1'b1;
    bus_s.abort = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      vectors++;
      if ({bus_s.busy, bus_s.rd_en, bus_s.done} !== 3'b000) begin
        miscompares++;
        $display("FAIL abort_start cyc=%0d got=%b exp=000", c, {bus_s.busy, bus_s.rd_en, bus_s.done});
      end
    end
    bus_s.start = 1'b0;
    bus_s.abort = 1'b0;
    next_cycle();
  endtask

  task automatic test_large_timing();
    int c;
    int last_wr;
    push_large(1'b1);
    bus_l.start = 1'b1;
    bus_l.inverse = 1'b1;
    next_cycle();
    bus_l.start = 1'b0;
    c = 1;
    last_wr = -1;
    while (bus_l.done !== 1'b1 && c < 3000) begin
      if (bus_l.wr_en === 1'b1) last_wr = c;
      next_cycle();
      c++;
    end
    vectors++;
    if (c != 2332) begin
      miscompares++;
      $display("FAIL large_done_cycle got=%0d exp=2332", c);
    end
    vectors++;
    if (last_wr != 2331 || bus_l.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL large_last_wr got=%0d busy=%b exp=2331 busy=0", last_wr, bus_l.busy);
    end
    next_cycle();
    check_drained("large_queues");
  endtask

  task automatic test_async_reset();
    push_large(1'b0);
    bus_l.start = 1'b1;
    bus_l.inverse = 1'b0;
    next_cycle();
    bus_l.start = 1'b0;
    repeat (999) next_cycle();
    vectors++;
    if ({bus_l.busy, bus_l.rd_en, bus_l.stage} !== 6'b110011) begin
      miscompares++;
      $display("FAIL areset_pre got=%b exp=110011", {bus_l.busy, bus_l.rd_en, bus_l.stage});
    end
    #2 reset = 1'b1;
    #1;
    lq_rd.delete();
    lq_wr.delete();
    vectors++;
    if ({bus_l.busy, bus_l.done, bus_l.rd_en, bus_l.wr_en, bus_l.tw_conj, bus_l.stage,
         bus_l.rd_addr_a, bus_l.rd_addr_b, bus_l.tw_addr, bus_l.wr_addr_a, bus_l.wr_addr_b} !== '0) begin
      miscompares++;
      $display("FAIL areset_now got=%b exp=0", {bus_l.busy, bus_l.rd_en, bus_l.wr_en, bus_l.stage});
    end
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      vectors++;
      if ({bus_l.busy, bus_l.done, bus_l.rd_en, bus_l.wr_en} !== 4'b0000) begin
        miscompares++;
        $display("FAIL areset_after cyc=%0d got=%b exp=0000", c,
                 {bus_l.busy, bus_l.done, bus_l.rd_en, bus_l.wr_en});
      end
    end
    check_drained("areset_queues");
  endtask

  initial begin
    test_reset();
    test_full_run(1'b0, 1'b0);
    test_full_run(1'b1, 1'b1);
    test_start_held();
    test_abort();
    test_full_run(1'b0, 1'b0);
    test_abort_start_idle();
    test_large_timing();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_agu_pipe.md
Name: fft_agu_pipe

Overview:
- Pipelined, parametrised address generation unit and sequencer for an in-place radix-2 FFT on a dual-port data RAM.
- Issues one butterfly read per clock. Replays the same addresses as write strobes exactly LAT cycles later, which matches the RAM read latency plus the BFU pipeline depth.
- Drains the pipeline between stages.
- Runs a start/busy/done handshake with the top-level FSM, and supports abort and an inverse-FFT twiddle-conjugate mode.

Parameters:
- LOG_N, 9, log2 of FFT length N; legal range 2..15.
- LAT, 3, cycles from rd_en to the matching wr_en; legal range 1..15.
- STG_W, $clog2(LOG_N+1), width of the stage index.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  level; sampled only in IDLE; launches the FFT
- abort  in  1  synchronous cancel
- inverse  in  1  sampled with start; selects conjugated twiddles
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- stage  out  STG_W  current stage index s
- rd_en  out  1  butterfly read strobe
- rd_addr_a  out  LOG_N  RAM port A read address
- rd_addr_b  out  LOG_N  RAM port B read address
- tw_addr  out  LOG_N-1  twiddle ROM address, aligned with rd_en
- tw_conj  out  1  conjugate twiddle; latched inverse
- wr_en  out  1  write strobe, LAT cycles after rd_en
- wr_addr_a  out  LOG_N  delayed rd_addr_a
- wr_addr_b  out  LOG_N  delayed rd_addr_b

Behaviour:
- Reset: state IDLE; all outputs 0; counters, delay line and valid bits cleared.
- States:
  - IDLE: start=1 and abort=0 -> RUN; inverse latched into tw_conj; s=0, j=0.
  - RUN: rd_en=1 every cycle; j increments.
    - When j=N/2-1: go to DRAIN, drain counter d=0.
  - DRAIN: rd_en=0; d counts up.
    - When d=LAT-1 and s<LOG_N-1: s++, j=0, go to RUN.
    - When d=LAT-1 and s=LOG_N-1: go to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- busy: 1 in RUN and DRAIN, 0 in IDLE and DONE.
- Addresses, combinational from registered s and j:
  - ja = {j,1'b0}; jb = {j,1'b1}.
  - rd_addr_a = rotate-left(ja, s) within LOG_N bits; rd_addr_b = rotate-left(jb, s) within LOG_N bits.
  - tw_addr = j AND mask_s, where mask_s has its top s bits (of LOG_N-1) set and the rest 0.
  - Stage 0 gives tw_addr=0. Stage LOG_N-1 gives tw_addr=j.
- Write path:
  - An LAT-deep shift register carries {valid, addr_a, addr_b}, loaded every cycle with {rd_en, rd_addr_a, rd_addr_b}.
  - wr_en = valid at the output; wr_addr_a and wr_addr_b are the delayed addresses.
  - The delayed addresses are don't-care when wr_en=0; a bench must not check them then.
  - DRAIN of LAT cycles guarantees the last write of stage s lands before the first read of stage s+1; no read-after-write hazard.
- Timing, with start seen at edge 0:
  - First rd_en at cycle 1.
  - Each stage takes N/2 + LAT cycles.
  - done at cycle 1 + LOG_N*(N/2+LAT).
  - The final wr_en is in the cycle before done.
- Boundary cases:
  - start while busy: ignored.
  - start held high after done: a new run starts on the IDLE cycle after DONE.
  - abort in any state: next state IDLE; all delay-line valid bits cleared; no further wr_en; no done; tw_conj unchanged.
  - abort and start together in IDLE: abort wins; state stays IDLE.
  - reset mid-run: immediate return to the reset state; no done.
  - j and s never wrap within a run. Counters are sized exactly: j is LOG_N-1 bits, s is STG_W bits.

Decomposition:
- fft_pkg holds:
  - the state enum {IDLE, RUN, DRAIN, DONE}
  - a function rotl(value, amount, width)
  - a function tw_mask(s, width)
- Sub-module fft_pipe_delay #(W, DEPTH): shift register with a synchronous per-stage valid clear (flush) and async reset. It is instantiated once for the write path.

Test Plan (LOG_N=3, LAT=2 unless stated):
- Stage 0: start pulse -> at cycles 1..4, rd_addr_a=0,2,4,6; rd_addr_b=1,3,5,7; tw_addr=0; wr_en at cycles 3..6 with the same address pairs.
- Stage 1 (cycles 7..10): rd_addr_a=0,4,1,5; rd_addr_b=2,6,3,7; tw_addr=0,0,2,2.
- Stage 2 (cycles 13..16): rd_addr_a=0,1,2,3; rd_addr_b=4,5,6,7; tw_addr=0,1,2,3; last wr_en at cycle 18; done=1 and busy=0 at cycle 19 only.
- inverse=1 with start -> tw_conj=1 for the whole run. Start asserted at cycle 5 during the run -> ignored; done still at 19.
- abort at cycle 8 -> busy=0 at cycle 9; no wr_en from cycle 9 on; done never asserts. A restart then reproduces the stage-0 sequence.
- LOG_N=9, LAT=3: done exactly 1+9*(256+3)=2332 cycles after start. Each (A,B) address pair is written exactly once per stage. Async reset at cycle 1000 -> all outputs 0 immediately.
